// File: rtl/ecc_apb_regfile.sv
// APB register bank in front of the ECC datapath: configuration/data registers,
// one launch per CTRL write, an IDLE/START/BUSY tracker and a completion watchdog.
module ecc_apb_regfile #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       start,
    output logic [1:0]                 opcode,
    output logic [DATA_WIDTH-1:0]      data_in,
    output logic [1:0]                 codeword_width,
    output logic [DATA_WIDTH-1:0]      noise,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL   = AMBA_ADDR_WIDTH'(32'h0000_0000);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA   = AMBA_ADDR_WIDTH'(32'h0000_0004);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CWW    = AMBA_ADDR_WIDTH'(32'h0000_0008);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE  = AMBA_ADDR_WIDTH'(32'h0000_000C);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_STATUS = AMBA_ADDR_WIDTH'(32'h0000_0010);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_RESULT = AMBA_ADDR_WIDTH'(32'h0000_0014);

    localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [1:0]            opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic [1:0]            cww_q, cww_d;
    logic [DATA_WIDTH-1:0] noise_q, noise_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [1:0]            errors_q, errors_d;
    logic                  done_q, done_d;
    logic                  bad_op_q, bad_op_d;
    logic                  timeout_q, timeout_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic [AMBA_WORD-1:0]  prdata_q, prdata_d;

    logic                  wr_s;
    logic                  rd_setup_s;
    logic                  rd_done_s;
    logic                  busy_s;
    logic [AMBA_WORD-1:0]  rdata_s;

    assign wr_s       = PSEL & PENABLE & PWRITE;
    assign rd_setup_s = PSEL & ~PENABLE & ~PWRITE;
    assign rd_done_s  = PSEL & PENABLE & ~PWRITE;
    assign busy_s     = (state_q != ST_IDLE);

    // Decoded from the state register so it drops the moment reset asserts.
    assign start          = (state_q == ST_START);
    assign opcode         = opcode_q;
    assign data_in        = data_in_q;
    assign codeword_width = cww_q;
    assign noise          = noise_q;
    assign PRDATA         = prdata_q;

    // Read-back multiplexer; narrow fields are zero-extended.
    always_comb begin
        rdata_s = {AMBA_WORD{1'b0}};
        case (PADDR)
            ADDR_CTRL:   rdata_s = AMBA_WORD'(opcode_q);
            ADDR_DATA:   rdata_s = AMBA_WORD'(data_in_q);
            ADDR_CWW:    rdata_s = AMBA_WORD'(cww_q);
            ADDR_NOISE:  rdata_s = AMBA_WORD'(noise_q);
            ADDR_STATUS: rdata_s = AMBA_WORD'({timeout_q, bad_op_q, errors_q, done_q, busy_s});
            ADDR_RESULT: rdata_s = AMBA_WORD'(result_q);
            default:     rdata_s = {AMBA_WORD{1'b0}};
        endcase
    end

    // Next-state logic for the operation tracker and all registers.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        data_in_d = data_in_q;
        cww_d     = cww_q;
        noise_d   = noise_q;
        result_d  = result_q;
        errors_d  = errors_q;
        bad_op_d  = bad_op_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;

        if (rd_done_s && (PADDR == ADDR_STATUS)) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (rd_setup_s) begin
            prdata_d = rdata_s;
        end else begin
            prdata_d = prdata_q;
        end

        // A completion seen in the same cycle as a STATUS read keeps done set.
        case (state_q)
            ST_IDLE: begin
                if (wr_s) begin
                    case (PADDR)
                        ADDR_CTRL: begin
                            if (PWDATA[1:0] == 2'b11) begin
                                bad_op_d = 1'b1;
                            end else begin
                                opcode_d  = PWDATA[1:0];
                                state_d   = ST_START;
                                done_d    = 1'b0;
                                bad_op_d  = 1'b0;
                                timeout_d = 1'b0;
                                wdog_d    = {WDOG_W{1'b0}};
                            end
                        end
                        ADDR_DATA:  data_in_d = PWDATA[DATA_WIDTH-1:0];
                        ADDR_CWW:   cww_d     = PWDATA[1:0];
                        ADDR_NOISE: noise_d   = PWDATA[DATA_WIDTH-1:0];
                        default:    state_d   = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (operation_done) begin
                    result_d = data_out;
                    errors_d = num_of_errors;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(32'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 2'b00;
            data_in_q <= {DATA_WIDTH{1'b0}};
            cww_q     <= 2'b00;
            noise_q   <= {DATA_WIDTH{1'b0}};
            result_q  <= {DATA_WIDTH{1'b0}};
            errors_q  <= 2'b00;
            done_q    <= 1'b0;
            bad_op_q  <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= {WDOG_W{1'b0}};
            prdata_q  <= {AMBA_WORD{1'b0}};
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            data_in_q <= data_in_d;
            cww_q     <= cww_d;
            noise_q   <= noise_d;
            result_q  <= result_d;
            errors_q  <= errors_d;
            done_q    <= done_d;
            bad_op_q  <= bad_op_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
            prdata_q  <= prdata_d;
        end
    end

endmodule

// File: tb/tb_ecc_apb_regfile.sv
// Randomized bench for ecc_apb_regfile checked against a register-level model
// that reasons in terms of operation start/end edges rather than states.
module tb_ecc_apb_regfile;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        start;
    logic [1:0]  opcode;
    logic [31:0] data_in;
    logic [1:0]  codeword_width;
    logic [31:0] noise;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;

    ecc_apb_regfile #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .start(start), .opcode(opcode), .data_in(data_in),
        .codeword_width(codeword_width), .noise(noise), .operation_done(operation_done),
        .data_out(data_out), .num_of_errors(num_of_errors)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_start = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (start === 1'b1) n_start <= n_start + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register contents
    logic [1:0]  m_op, m_cw, m_err;
    logic [31:0] m_din, m_noise, m_res;
    logic        m_done, m_bad, m_to;
    int          m_starts = 0;

    task automatic model_clear();
        m_op = 2'd0; m_cw = 2'd0; m_err = 2'd0; m_din = 32'd0; m_noise = 32'd0; m_res = 32'd0;
        m_done = 1'b0; m_bad = 1'b0; m_to = 1'b0;
    endtask

    function automatic logic [31:0] mread(input logic [19:0] a, input logic busy);
        case (a)
            20'h00:  return {30'd0, m_op};
            20'h04:  return m_din;
            20'h08:  return {30'd0, m_cw};
            20'h0C:  return m_noise;
            20'h10:  return {26'd0, m_to, m_bad, m_err, m_done, busy};
            20'h14:  return m_res;
            default: return 32'd0;
        endcase
    endfunction

    // APB transfers, each called at a falling edge
    task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
        PADDR = a; PWDATA = d; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        @(negedge clk); PENABLE = 1'b1;
        @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a, output logic [31:0] d);
        PADDR = a; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge clk); PENABLE = 1'b1; d = PRDATA;
        @(negedge clk); PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle_write(input logic [19:0] a, input logic [31:0] d);
        apb_write(a, d);
        case (a)
            20'h00:  if (d[1:0] == 2'b11) m_bad = 1'b1;
            20'h04:  m_din = d;
            20'h08:  m_cw = d[1:0];
            20'h0C:  m_noise = d;
            default: ;
        endcase
    endtask

    task automatic idle_read(input logic [19:0] a);
        logic [31:0] d;
        apb_read(a, d);
        chk_val($sformatf("rd_%05h", a), d, mread(a, 1'b0));
        if (a == 20'h10) m_done = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        chk_val({tag, "_opcode"}, {30'd0, opcode}, {30'd0, m_op});
        chk_val({tag, "_data_in"}, data_in, m_din);
        chk_val({tag, "_cww"}, {30'd0, codeword_width}, {30'd0, m_cw});
        chk_val({tag, "_noise"}, noise, m_noise);
        chk_val({tag, "_starts"}, n_start, m_starts);
    endtask

    // One operation: done_off = edge offset of operation_done after the CTRL commit
    // (0 = never), probe_off = offset of a STATUS read setup edge (>= 6).
    task automatic run_op(input logic [1:0] op, input int done_off, input int probe_off,
                          input logic [31:0] dout, input logic [1:0] nerr);
        int n, e;
        bit valid, junk;
        logic [31:0] pd, exp;
        apb_write(20'h00, {$urandom} & 32'hFFFF_FFFC | {30'd0, op});
        n = cyc;
        chk_val("start_hi", {31'd0, start}, 32'd1);
        m_starts++; m_op = op; m_done = 1'b0; m_bad = 1'b0; m_to = 1'b0;
        valid = (done_off >= 2) && (done_off <= TO + 1);
        e = valid ? done_off : TO + 1;
        junk = !(done_off >= 2 && done_off <= 4);
        fork
            begin
                if (done_off > 0) begin
                    while (cyc < n + done_off - 1) @(negedge clk);
                    operation_done = 1'b1; data_out = dout; num_of_errors = nerr;
                    @(negedge clk);
                    operation_done = 1'b0; data_out = $urandom; num_of_errors = 2'd0;
                end
            end
            begin
                @(negedge clk);
                chk_val("start_lo", {31'd0, start}, 32'd0);
                if (junk) begin
                    apb_write(20'h04, 32'hFFFF_FFFF);
                    apb_write(20'h00, 32'h0000_0000);
                end
                while (cyc < n + probe_off - 1) @(negedge clk);
                apb_read(20'h10, pd);
            end
        join
        if (probe_off <= e) exp = mread(20'h10, 1'b1);
        if (valid) begin
            m_res = dout; m_err = nerr; m_done = 1'b1;
        end else begin
            m_to = 1'b1;
        end
        if (probe_off > e) exp = mread(20'h10, 1'b0);
        chk_val("status_probe", pd, exp);
        if (valid && e <= probe_off) m_done = 1'b0;
        while (cyc < n + e) @(negedge clk);
        check_outs("op");
    endtask

    logic [19:0] addrs [8] = '{20'h00, 20'h04, 20'h08, 20'h0C, 20'h10, 20'h14, 20'h18, 20'h10004};

    initial begin
        #3_000_000;
        $display("FAIL sim_limit: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; PADDR = 20'd0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = 32'd0;
        operation_done = 1'b0; data_out = 32'd0; num_of_errors = 2'd0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 7; i++) idle_read(addrs[i]);
        check_outs("rst");

        // Configure and run a decode that completes normally
        idle_write(20'h04, 32'hA5A5_0F0F);
        idle_write(20'h08, 32'h0000_0002);
        idle_write(20'h0C, 32'h0000_0001);
        check_outs("cfg");
        run_op(2'd1, 20, 6, 32'h1234_5678, 2'd2);
        idle_read(20'h14);
        idle_read(20'h10);
        idle_read(20'h10);
        idle_read(20'h04);

        // Illegal opcode, then watchdog boundaries on both sides of the abort edge
        idle_write(20'h00, 32'h0000_0003);
        idle_read(20'h10);
        idle_read(20'h00);
        check_outs("badop");
        run_op(2'd0, 0, TO + 1, 32'd0, 2'd0);
        idle_read(20'h10);
        run_op(2'd2, 0, TO + 2, 32'd0, 2'd0);
        // Completion in START is ignored; completion on the abort edge wins
        run_op(2'd0, 1, TO + 2, 32'hDEAD_BEEF, 2'd3);
        idle_read(20'h14);
        run_op(2'd1, TO + 1, TO + 2, 32'hCAFE_0001, 2'd1);
        idle_read(20'h14);
        idle_read(20'h10);
        run_op(2'd2, 2, 6, 32'h0BAD_F00D, 2'd3);
        idle_read(20'h10);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: idle_write(addrs[$urandom_range(1, 7)], $urandom);
                1: idle_read(addrs[$urandom_range(0, 7)]);
                2: idle_write(20'h00, ({$urandom} & 32'hFFFF_FFFC) | 32'h3);
                default: run_op(2'($urandom_range(0, 2)), $urandom_range(0, TO + 1),
                                $urandom_range(6, TO + 6), $urandom, 2'($urandom_range(0, 3)));
            endcase
        end
        check_outs("rand");

        // Reset in the middle of an operation
        idle_write(20'h04, 32'h5A5A_1234);
        idle_read(20'h04);
        apb_write(20'h00, 32'h0000_0002);
        m_starts++;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        chk_val("rst_prdata", PRDATA, 32'd0);
        chk_val("rst_start", {31'd0, start}, 32'd0);
        check_outs("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        operation_done = 1'b1; data_out = 32'h7777_7777; num_of_errors = 2'd3;
        @(negedge clk);
        operation_done = 1'b0;
        idle_read(20'h14);
        idle_read(20'h10);
        check_outs("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
